calc_parser: RTL and testbench

//  Upstream stage of the multiplier. Receives ASCII bytes from the UART receiver one strobe at a time.

---
 rtl/calc_pkg.sv | 23 ++
 rtl/calc_dec_acc.sv | 40 ++++
 rtl/calc_parser.sv | 136 +++++++++++++
 tb/tb_calc_parser.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: ASCII codes, parser states and operand limits shared by the calc blocks
package calc_pkg;
    localparam int CALC_W      = 16;
    localparam int CALC_DIGITS = 5;
    localparam int POS_MAX     = 2 ** (CALC_W - 1) - 1;
    localparam int NEG_MAX     = 2 ** (CALC_W - 1);
    localparam logic [7:0] CHAR_0     = 8'h30;
    localparam logic [7:0] CHAR_9     = 8'h39;
    localparam logic [7:0] CHAR_MINUS = 8'h2D;
    localparam logic [7:0] CHAR_STAR  = 8'h2A;
    localparam logic [7:0] CHAR_SP    = 8'h20;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    typedef enum logic [2:0] {
        S1_SIGN,
        S1_DIG,
        S2_SIGN,
        S2_DIG,
        COMMIT,
        WAIT,
        ERR
    } state_t;
endpackage

// File: rtl/calc_dec_acc.sv
// calc_dec_acc: decimal magnitude accumulator with digit count and range check
module calc_dec_acc
    import calc_pkg::*;
#(
    parameter int DATA_W     = CALC_W,
    parameter int MAX_DIGITS = CALC_DIGITS,
    parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clr,
    input  logic              en,
    input  logic              neg,
    input  logic [3:0]        digit,
    output logic [DATA_W:0]   acc,
    output logic              has_dig,
    output logic              ovf
);
    localparam int WW = DATA_W + 4;
    logic [DATA_W:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WW-1:0] wide;
    always_comb begin
        wide    = (WW'(acc_q) << 3) + (WW'(acc_q) << 1) + WW'(digit);
        ovf     = (int'(cnt_q) >= MAX_DIGITS) || (wide > (neg ? WW'(NEG_MAX) : WW'(POS_MAX)));
        acc_d   = clr ? '0 : en ? wide[DATA_W:0] : acc_q;
        cnt_d   = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
        acc     = acc_q;
        has_dig = cnt_q != '0;
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/calc_parser.sv
// calc_parser: parses "<op1>*<op2><CR|LF>" ASCII frames into two signed operands
module calc_parser
    import calc_pkg::*;
#(
    parameter int DATA_W     = CALC_W,
    parameter int MAX_DIGITS = CALC_DIGITS
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              booth_done,
    output logic [DATA_W-1:0] src1,
    output logic [DATA_W-1:0] src2,
    output logic              parser_done,
    output logic              parse_err
);
    state_t st, state_q, state_d;
    logic neg1_q, neg1_d, neg2_q, neg2_d, done_q, done_d, err_q, err_d;
    logic [DATA_W-1:0] op1_q, op1_d, src1_q, src1_d, src2_q, src2_d;
    logic acc_clr, acc_en, acc_neg, has_dig, ovf, bad;
    logic [DATA_W:0] acc;
    logic is_dig, is_minus, is_star, is_sp, is_eol;

    function automatic logic [DATA_W-1:0] twos(input logic [DATA_W:0] m, input logic n);
        return DATA_W'(n ? ~m + {{DATA_W{1'b0}}, 1'b1} : m);
    endfunction

    assign is_dig   = rx_data >= CHAR_0 && rx_data <= CHAR_9;
    assign is_minus = rx_data == CHAR_MINUS;
    assign is_star  = rx_data == CHAR_STAR;
    assign is_sp    = rx_data == CHAR_SP;
    assign is_eol   = rx_data == CHAR_CR || rx_data == CHAR_LF;

    calc_dec_acc #(.DATA_W(DATA_W), .MAX_DIGITS(MAX_DIGITS)) u_acc (
        .clk     (clk),
        .n_rst   (n_rst),
        .clr     (acc_clr),
        .en      (acc_en),
        .neg     (acc_neg),
        .digit   (rx_data[3:0]),
        .acc     (acc),
        .has_dig (has_dig),
        .ovf     (ovf)
    );

    // booth_done in WAIT hands this cycle's byte straight to S1_SIGN
    always_comb begin
        st      = (state_q == WAIT && booth_done) ? S1_SIGN : state_q;
        state_d = st;
        neg1_d  = neg1_q;
        neg2_d  = neg2_q;
        op1_d   = op1_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        bad     = 1'b0;
        acc_neg = (st == S1_DIG) ? neg1_q : (st == S2_DIG) ? neg2_q : 1'b0;
        if (st == COMMIT) begin
            src1_d  = op1_q;
            src2_d  = twos(acc, neg2_q);
            done_d  = 1'b1;
            acc_clr = 1'b1;
            err_d   = rx_done;
            state_d = WAIT;
        end else if (rx_done && st == WAIT) begin
            err_d = 1'b1;
        end else if (rx_done && st == ERR) begin
            acc_clr = 1'b1;
            err_d   = is_eol;
            state_d = is_eol ? S1_SIGN : ERR;
        end else if (rx_done && !is_sp) begin
            case (st)
                S1_SIGN: begin
                    neg1_d  = is_minus;
                    bad     = !(is_minus || is_dig || is_eol);
                    state_d = (is_minus || is_dig) ? S1_DIG : S1_SIGN;
                end
                S1_DIG: begin
                    bad     = !(is_dig || (is_star && has_dig));
                    op1_d   = is_star ? twos(acc, neg1_q) : op1_q;
                    acc_clr = is_star;
                    state_d = is_star ? S2_SIGN : S1_DIG;
                end
                S2_SIGN: begin
                    neg2_d  = is_minus;
                    bad     = !(is_minus || is_dig);
                    state_d = S2_DIG;
                end
                S2_DIG: begin
                    bad     = !(is_dig || (is_eol && has_dig));
                    state_d = is_eol ? COMMIT : S2_DIG;
                end
                default: ;
            endcase
            bad    = bad || (is_dig && ovf);
            acc_en = is_dig && !bad;
            // a terminator that kills the frame also ends it, so it reports at once
            if (bad) begin
                acc_clr = 1'b1;
                err_d   = is_eol;
                state_d = is_eol ? S1_SIGN : ERR;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S1_SIGN;
            neg1_q  <= 1'b0;
            neg2_q  <= 1'b0;
            op1_q   <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            neg1_q  <= neg1_d;
            neg2_q  <= neg2_d;
            op1_q   <= op1_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign src1        = src1_q;
    assign src2        = src2_q;
    assign parser_done = done_q;
    assign parse_err   = err_q;
endmodule

// File: tb/tb_calc_parser.sv
// tb_calc_parser: directed frames with a queue-based scoreboard on parser_done/parse_err
module tb_calc_parser;
    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic        booth_done = 1'b0;
    logic [15:0] src1, src2;
    logic        parser_done, parse_err;

    typedef struct {
        logic        err;
        logic [15:0] s1;
        logic [15:0] s2;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] hs1 = 16'h0000;
    logic [15:0] hs2 = 16'h0000;
    localparam byte CR = 8'h0D;
    localparam byte LF = 8'h0A;

    calc_parser dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .booth_done  (booth_done),
        .src1        (src1),
        .src2        (src2),
        .parser_done (parser_done),
        .parse_err   (parse_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ev: 0 nothing, 1 parse_err next cycle, 2 parser_done with (e1,e2) one cycle later
    task automatic send(input byte b, input int ev, input logic [15:0] e1, input logic [15:0] e2,
                        input logic bd);
        @(negedge clk);
        if (ev == 2) begin
            hs1 = e1;
            hs2 = e2;
        end
        if (ev != 0) exp_q.push_back('{ev == 1, hs1, hs2, cyc + ev});
        rx_data    = b;
        rx_done    = 1'b1;
        booth_done = bd;
        @(negedge clk);
        rx_done    = 1'b0;
        booth_done = 1'b0;
    endtask

    task automatic frame(input string s, input byte term, input int ev, input logic [15:0] e1,
                         input logic [15:0] e2);
        for (int i = 0; i < s.len(); i++) send(s[i], 0, 16'h0, 16'h0, 1'b0);
        if (term != 8'h00) send(term, ev, e1, e2, 1'b0);
    endtask

    task automatic release_op;
        @(negedge clk);
        booth_done = 1'b1;
        @(negedge clk);
        booth_done = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (n_rst && (parser_done || parse_err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: done=%b err=%b src1=%h src2=%h at cycle %0d",
                         parser_done, parse_err, src1, src2, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("kind", {30'd0, parser_done, parse_err}, e.err ? 32'd1 : 32'd2);
                chk("cycle", cyc, e.due);
                chk("src1", {16'd0, src1}, {16'd0, e.s1});
                chk("src2", {16'd0, src2}, {16'd0, e.s2});
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_src1", {16'd0, src1}, 32'd0);
        chk("rst_src2", {16'd0, src2}, 32'd0);
        chk("rst_done", {31'd0, parser_done}, 32'd0);
        chk("rst_err", {31'd0, parse_err}, 32'd0);
        n_rst = 1'b1;
        frame("12*34", CR, 2, 16'h000C, 16'h0022);
        release_op();
        frame("-32768*32767", LF, 2, 16'h8000, 16'h7FFF);
        release_op();
        frame("", CR, 0, 16'h0, 16'h0);
        frame("", LF, 0, 16'h0, 16'h0);
        frame("32768*1", CR, 1, 16'h0, 16'h0);
        frame("123456*1", CR, 1, 16'h0, 16'h0);
        frame(" 7 * -3 ", CR, 2, 16'h0007, 16'hFFFD);
        release_op();
        frame("5*", CR, 1, 16'h0, 16'h0);
        frame("*5", CR, 1, 16'h0, 16'h0);
        frame("--5*1", CR, 1, 16'h0, 16'h0);
        frame("2*3", CR, 2, 16'h0002, 16'h0003);
        send("9", 1, 16'h0, 16'h0, 1'b0);
        send("4", 0, 16'h0, 16'h0, 1'b1);
        frame("*2", CR, 2, 16'h0004, 16'h0002);
        release_op();
        frame("12*", 8'h00, 0, 16'h0, 16'h0);
        @(negedge clk);
        n_rst = 1'b0;
        hs1 = 16'h0000;
        hs2 = 16'h0000;
        @(negedge clk);
        chk("mid_rst_src1", {16'd0, src1}, 32'd0);
        chk("mid_rst_src2", {16'd0, src2}, 32'd0);
        chk("mid_rst_done", {31'd0, parser_done}, 32'd0);
        chk("mid_rst_err", {31'd0, parse_err}, 32'd0);
        n_rst = 1'b1;
        frame("34", CR, 1, 16'h0, 16'h0);
        repeat (10) @(negedge clk);
        chk("pending_events", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
